// File: rtl/box_painter.sv
// Pixel generator: paints a framed TAM x TAM square over a background from raster
// counters, with the square position captured once per frame and a 2-clk output pipeline.
module box_painter #(
  parameter logic [10:0] TAM      = 11'd64,
  parameter logic [10:0] BORDER   = 11'd2,
  parameter int          CW       = 8,
  parameter logic [23:0] BG_RGB   = 24'h000040,
  parameter logic [23:0] BOX_RGB  = 24'hFFFF00,
  parameter logic [23:0] EDGE_RGB = 24'hFFFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   hc,
  input  logic [10:0]   vc,
  input  logic          display_en,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [10:0]   posx,
  input  logic [10:0]   posy,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_sync
);

  function automatic logic [3*CW-1:0] chan(input logic [23:0] c);
    return {c[23 -: CW], c[15 -: CW], c[7 -: CW]};
  endfunction

  localparam logic [3*CW-1:0] BG_C   = chan(BG_RGB);
  localparam logic [3*CW-1:0] BOX_C  = chan(BOX_RGB);
  localparam logic [3*CW-1:0] EDGE_C = chan(EDGE_RGB);

  logic [10:0] px, py;
  logic        frame_start;

  logic [11:0] xs, xe, ys, ye, h12, v12, tam12, bor12;
  logic        inx, iny, in_sq, on_edge;

  logic        s1_in, s1_edge, s1_de, s1_hs, s1_vs;
  logic [3*CW-1:0] colour;

  assign frame_start = (hc == '0) && (vc == '0) && display_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px         <= '0;
      py         <= '0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= frame_start;
      if (frame_start) begin
        px <= posx;
        py <= posy;
      end
    end
  end

  // 12-bit arithmetic keeps the right/bottom edge from wrapping near 2047.
  always_comb begin
    h12     = {1'b0, hc};
    v12     = {1'b0, vc};
    tam12   = {1'b0, TAM};
    bor12   = {1'b0, BORDER};
    xs      = {1'b0, px};
    xe      = xs + tam12;
    ys      = {1'b0, py};
    ye      = ys + tam12;
    inx     = (h12 >= xs) && (h12 < xe);
    iny     = (v12 >= ys) && (v12 < ye);
    in_sq   = inx && iny;
    on_edge = in_sq && ((h12 < xs + bor12) || (h12 >= xe - bor12) ||
                        (v12 < ys + bor12) || (v12 >= ye - bor12));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_in   <= 1'b0;
      s1_edge <= 1'b0;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
    end else begin
      s1_in   <= in_sq;
      s1_edge <= on_edge;
      s1_de   <= display_en;
      s1_hs   <= hsync_in;
      s1_vs   <= vsync_in;
    end
  end

  always_comb begin
    colour = '0;
    if (s1_de) begin
      if (s1_edge)    colour = EDGE_C;
      else if (s1_in) colour = BOX_C;
      else            colour = BG_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      {r, g, b} <= colour;
      hsync     <= s1_hs;
      vsync     <= s1_vs;
    end
  end

endmodule

// File: tb/tb_box_painter.sv
// Directed testbench for box_painter: pixel colours, latency, frame snapshot,
// clipping, overflow and mid-frame reset.
module tb_box_painter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hc = '0, vc = '0, posx = '0, posy = '0;
  logic        display_en = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, frame_sync;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] C_BG   = 24'h000040;
  localparam logic [23:0] C_BOX  = 24'hFFFF00;
  localparam logic [23:0] C_EDGE = 24'hFFFFFF;

  always #5 clk = ~clk;

  box_painter #(
    .TAM(11'd64), .BORDER(11'd2), .CW(8),
    .BG_RGB(24'h000040), .BOX_RGB(24'hFFFF00), .EDGE_RGB(24'hFFFFFF)
  ) dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .display_en(display_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .posx(posx), .posy(posy),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .frame_sync(frame_sync)
  );

  // Drive one pixel and hold it until its result reaches the outputs.
  task automatic hold_pixel(input logic [10:0] h, input logic [10:0] v, input logic de);
    @(negedge clk);
    hc = h; vc = v; display_en = de;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Present the frame-start pixel for one cycle, then move to hc=1.
  // Returns at the negedge where frame_sync should be high.
  task automatic frame_start();
    @(negedge clk);
    hc = 11'd0; vc = 11'd0; display_en = 1'b1;
    @(negedge clk);
    hc = 11'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hc = 11'(i); vc = 11'd0; display_en = 1'b1;
      hsync_in = i[0]; vsync_in = ~i[0];
      posx = 11'd0; posy = 11'd0;
    end
    @(negedge clk);
    checks++;
    if ({r, g, b, hsync, vsync, frame_sync} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rgb=%h hs=%b vs=%b fs=%b, expected all 0",
               {r, g, b}, hsync, vsync, frame_sync);
    end
    hsync_in = 1'b0; vsync_in = 1'b0; hc = 11'd5; vc = 11'd5;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pixels();
    logic [10:0] hv [5];
    logic [10:0] vv [5];
    logic [23:0] ev [5];
    hv = '{11'd100, 11'd102, 11'd99, 11'd163, 11'd164};
    vv = '{11'd50,  11'd52,  11'd50, 11'd113, 11'd113};
    ev = '{C_EDGE, C_BOX, C_BG, C_EDGE, C_BG};
    posx = 11'd100; posy = 11'd50;
    frame_start();
    for (int i = 0; i < 5; i++) begin
      hold_pixel(hv[i], vv[i], 1'b1);
      checks++;
      if ({r, g, b} !== ev[i]) begin
        errors++;
        $display("FAIL pixel(%0d,%0d): got %h, expected %h", hv[i], vv[i], {r, g, b}, ev[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic [10:0] hv [8];
    logic [23:0] ev [8];
    logic        hs [8];
    logic        vs [8];
    hv = '{11'd98, 11'd99, 11'd100, 11'd101, 11'd102, 11'd103, 11'd164, 11'd163};
    ev = '{C_BG, C_BG, C_EDGE, C_EDGE, C_BOX, C_BOX, C_BG, C_EDGE};
    hs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if ({r, g, b} !== ev[i-2] || hsync !== hs[i-2] || vsync !== vs[i-2]) begin
          errors++;
          $display("FAIL latency[%0d]: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                   i - 2, {r, g, b}, hsync, vsync, ev[i-2], hs[i-2], vs[i-2]);
        end
      end
      if (i < 8) begin
        hc = hv[i]; vc = 11'd60; display_en = 1'b1;
        hsync_in = hs[i]; vsync_in = vs[i];
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic test_snapshot();
    int pulses;
    hold_pixel(11'd120, 11'd200, 1'b1);
    posx = 11'd300;
    hold_pixel(11'd120, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_BOX) begin
      errors++;
      $display("FAIL snap_old_pos: got %h, expected %h", {r, g, b}, C_BOX);
    end
    hold_pixel(11'd310, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_BG) begin
      errors++;
      $display("FAIL snap_no_early: got %h, expected %h", {r, g, b}, C_BG);
    end
    frame_start();
    checks++;
    if (frame_sync !== 1'b1) begin
      errors++;
      $display("FAIL frame_sync_pulse: got %b, expected 1", frame_sync);
    end
    @(negedge clk);
    checks++;
    if (frame_sync !== 1'b0 || {r, g, b} !== C_BG) begin
      errors++;
      $display("FAIL frame_first_pixel: got fs=%b rgb=%h, expected fs=0 rgb=%h",
               frame_sync, {r, g, b}, C_BG);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hc = 11'(310 + i); vc = 11'd60;
      if (frame_sync === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL frame_sync_once: got %0d extra pulses, expected 0", pulses);
    end
    hold_pixel(11'd310, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_BOX) begin
      errors++;
      $display("FAIL snap_new_pos: got %h, expected %h", {r, g, b}, C_BOX);
    end
  endtask

  task automatic test_display_en();
    hold_pixel(11'd310, 11'd60, 1'b0);
    checks++;
    if ({r, g, b} !== 24'h0) begin
      errors++;
      $display("FAIL blank_inside: got %h, expected 000000", {r, g, b});
    end
  endtask

  task automatic test_clip();
    posx = 11'd600; posy = 11'd50;
    frame_start();
    hold_pixel(11'd600, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_EDGE) begin
      errors++;
      $display("FAIL clip_left_edge: got %h, expected %h", {r, g, b}, C_EDGE);
    end
    hold_pixel(11'd639, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_BOX) begin
      errors++;
      $display("FAIL clip_col639: got %h, expected %h", {r, g, b}, C_BOX);
    end
    hold_pixel(11'd10, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_BG) begin
      errors++;
      $display("FAIL clip_no_wrap: got %h, expected %h", {r, g, b}, C_BG);
    end
    posx = 11'd2040;
    frame_start();
    hold_pixel(11'd10, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_BG) begin
      errors++;
      $display("FAIL overflow_col10: got %h, expected %h", {r, g, b}, C_BG);
    end
    hold_pixel(11'd0, 11'd60, 1'b1);
    checks++;
    if ({r, g, b} !== C_BG) begin
      errors++;
      $display("FAIL overflow_col0: got %h, expected %h", {r, g, b}, C_BG);
    end
  endtask

  task automatic test_mid_reset();
    posx = 11'd100; posy = 11'd200;
    frame_start();
    hold_pixel(11'd120, 11'd240, 1'b1);
    checks++;
    if ({r, g, b} !== C_BOX) begin
      errors++;
      $display("FAIL prereset_box: got %h, expected %h", {r, g, b}, C_BOX);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r, g, b, hsync, vsync, frame_sync} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset: got rgb=%h hs=%b vs=%b fs=%b, expected all 0",
               {r, g, b}, hsync, vsync, frame_sync);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold_pixel(11'd10, 11'd10, 1'b1);
    checks++;
    if ({r, g, b} !== C_BOX) begin
      errors++;
      $display("FAIL reset_origin: got %h, expected %h", {r, g, b}, C_BOX);
    end
    hold_pixel(11'd120, 11'd240, 1'b1);
    checks++;
    if ({r, g, b} !== C_BG) begin
      errors++;
      $display("FAIL reset_old_gone: got %h, expected %h", {r, g, b}, C_BG);
    end
    frame_start();
    hold_pixel(11'd120, 11'd240, 1'b1);
    checks++;
    if ({r, g, b} !== C_BOX) begin
      errors++;
      $display("FAIL reset_new_frame: got %h, expected %h", {r, g, b}, C_BOX);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_pixels();
    test_latency();
    test_snapshot();
    test_display_en();
    test_clip();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
